// File: rtl/mips8_wb_pkg.sv
// rtl/mips8_wb_pkg.sv - shared constants and types for the MIPS8 Wishbone responder
package mips8_wb_pkg;

  localparam logic [1:0] REGION_REGS = 2'd0;
  localparam logic [1:0] REGION_IMEM = 2'd1;

  // Register offsets expressed as word indices (byte offset >> 2)
  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_STATUS   = 8'h01;
  localparam logic [7:0] REG_GPIO_OUT = 8'h02;
  localparam logic [7:0] REG_GPIO_OEB = 8'h03;
  localparam logic [7:0] REG_GPIO_IN  = 8'h04;
  localparam logic [7:0] REG_CYCLES   = 8'h05;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_CRST     = 1;
  localparam int CTRL_STEP     = 2;
  localparam int CTRL_IRQEN    = 3;
  localparam int STATUS_HALTED = 0;
  localparam int STATUS_PC_LSB = 8;
  localparam int STATUS_STICKY = 16;

  localparam logic        CTRL_CRST_RST = 1'b1;
  localparam logic [15:0] GPIO_OUT_RST  = 16'h0000;
  localparam logic [15:0] GPIO_OEB_RST  = 16'hFFFF;

  typedef enum logic [1:0] {
    WB_IDLE   = 2'd0,
    WB_RDWAIT = 2'd1,
    WB_ACK    = 2'd2
  } wb_state_t;

  function automatic logic [15:0] apply_sel16(input logic [15:0] cur,
                                              input logic [15:0] wdat,
                                              input logic [1:0]  sel);
    apply_sel16 = cur;
    if (sel[0]) apply_sel16[7:0]  = wdat[7:0];
    if (sel[1]) apply_sel16[15:8] = wdat[15:8];
  endfunction

endpackage

// File: rtl/wb_mips8_responder.sv
// rtl/wb_mips8_responder.sv - Wishbone classic responder for MIPS8 control, IMEM and GPIO
module wb_mips8_responder
  import mips8_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        imem_we_o,
  output logic [7:0]  imem_addr_o,
  output logic [7:0]  imem_wdata_o,
  input  logic [7:0]  imem_rdata_i,
  output logic        core_run_o,
  output logic        core_rst_o,
  output logic        core_step_o,
  input  logic        core_halted_i,
  input  logic [7:0]  core_pc_i,
  output logic [15:0] gpio_out_o,
  output logic [15:0] gpio_oeb_o,
  input  logic [7:0]  gpio_in_i,
  output logic        irq_o
);

  wb_state_t   state_q, state_d;
  logic        run_q, crst_q, irqen_q, step_q, sticky_q, halted_prev_q;
  logic [15:0] gpio_out_q, gpio_oeb_q;
  logic [31:0] cycles_q, dat_q, reg_rdata;
  logic        imem_we_q;
  logic [7:0]  imem_addr_q, imem_wdata_q;
  logic        hit, req, take, is_regs, is_imem, reg_wr, halt_rise;
  logic [7:0]  word_idx;
  logic        unused_bits;

  assign hit       = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign req       = wbs_cyc_i & wbs_stb_i & hit;
  assign take      = (state_q == WB_IDLE) & req;
  assign is_regs   = (wbs_adr_i[11:10] == REGION_REGS);
  assign is_imem   = (wbs_adr_i[11:10] == REGION_IMEM);
  assign word_idx  = wbs_adr_i[9:2];
  assign reg_wr    = take & wbs_we_i & is_regs;
  assign halt_rise = core_halted_i & ~halted_prev_q;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:17], wbs_sel_i[3]};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= WB_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_IDLE:   if (req) state_d = (is_imem && !wbs_we_i) ? WB_RDWAIT : WB_ACK;
      WB_RDWAIT: state_d = WB_ACK;
      WB_ACK:    state_d = WB_IDLE;
      default:   state_d = WB_IDLE;
    endcase
  end

  always_comb begin
    reg_rdata = 32'd0;
    case (word_idx)
      REG_CTRL: begin
        reg_rdata[CTRL_RUN]   = run_q;
        reg_rdata[CTRL_CRST]  = crst_q;
        reg_rdata[CTRL_IRQEN] = irqen_q;
      end
      REG_STATUS: begin
        reg_rdata[STATUS_HALTED]      = core_halted_i;
        reg_rdata[STATUS_PC_LSB +: 8] = core_pc_i;
        reg_rdata[STATUS_STICKY]      = sticky_q;
      end
      REG_GPIO_OUT: reg_rdata[15:0] = gpio_out_q;
      REG_GPIO_OEB: reg_rdata[15:0] = gpio_oeb_q;
      REG_GPIO_IN:  reg_rdata[7:0]  = gpio_in_i;
      REG_CYCLES:   reg_rdata       = cycles_q;
      default:      reg_rdata       = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    halted_prev_q <= core_halted_i;
    if (wb_rst_i) begin
      run_q        <= 1'b0;
      crst_q       <= CTRL_CRST_RST;
      irqen_q      <= 1'b0;
      step_q       <= 1'b0;
      sticky_q     <= 1'b0;
      gpio_out_q   <= GPIO_OUT_RST;
      gpio_oeb_q   <= GPIO_OEB_RST;
      cycles_q     <= 32'd0;
      dat_q        <= 32'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= 8'd0;
      imem_wdata_q <= 8'd0;
    end else begin
      step_q    <= 1'b0;
      imem_we_q <= 1'b0;
      if (run_q && !crst_q) cycles_q <= cycles_q + 32'd1;
      if (take) dat_q <= (is_regs && !wbs_we_i) ? reg_rdata : 32'd0;
      if (state_q == WB_RDWAIT) dat_q <= {24'd0, imem_rdata_i};
      if (reg_wr) begin
        case (word_idx)
          REG_CTRL: if (wbs_sel_i[0]) begin
            run_q   <= wbs_dat_i[CTRL_RUN];
            crst_q  <= wbs_dat_i[CTRL_CRST];
            irqen_q <= wbs_dat_i[CTRL_IRQEN];
            // Step is judged against the values being written in the same access
            step_q  <= wbs_dat_i[CTRL_STEP] & ~wbs_dat_i[CTRL_RUN] & ~wbs_dat_i[CTRL_CRST];
          end
          REG_STATUS:   if (wbs_sel_i[2] && wbs_dat_i[STATUS_STICKY]) sticky_q <= 1'b0;
          REG_GPIO_OUT: gpio_out_q <= apply_sel16(gpio_out_q, wbs_dat_i[15:0], wbs_sel_i[1:0]);
          REG_GPIO_OEB: gpio_oeb_q <= apply_sel16(gpio_oeb_q, wbs_dat_i[15:0], wbs_sel_i[1:0]);
          REG_CYCLES:   cycles_q   <= 32'd0;
          default:      ;
        endcase
      end
      if (take && is_imem) begin
        if (!wbs_we_i) begin
          imem_addr_q <= word_idx;
        end else if (wbs_sel_i[0] && !run_q) begin
          imem_we_q    <= 1'b1;
          imem_addr_q  <= word_idx;
          imem_wdata_q <= wbs_dat_i[7:0];
        end
      end
      // Placed last so a halt beats a same-cycle CTRL write or sticky clear
      if (halt_rise) begin
        run_q    <= 1'b0;
        sticky_q <= 1'b1;
      end
    end
  end

  assign wbs_ack_o    = (state_q == WB_ACK);
  assign wbs_dat_o    = wbs_ack_o ? dat_q : 32'd0;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign core_run_o   = run_q & ~crst_q;
  assign core_rst_o   = crst_q;
  assign core_step_o  = step_q;
  assign gpio_out_o   = gpio_out_q;
  assign gpio_oeb_o   = gpio_oeb_q;
  assign irq_o        = sticky_q & irqen_q;

endmodule
